// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with clear sweep and dump port
module regfile_mp #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NRD*AW-1:0]   RUrs,
   output logic [NRD*XLEN-1:0] RUout,
   input  logic [AW-1:0]       RUrd,
   input  logic [XLEN-1:0]     RUDatawr,
   input  logic                RUWr,
   output logic                RUReady,
   input  logic                DumpReq,
   output logic                DumpValid,
   input  logic                DumpReady,
   output logic [AW-1:0]       DumpIdx,
   output logic [XLEN-1:0]     DumpData,
   output logic                DumpLast
);

   typedef enum logic {INIT, RUN} main_t;
   typedef enum logic {IDLE, ACTIVE} dump_t;

   main_t           state;
   dump_t           dstate;
   logic [AW-1:0]   cnt;
   logic [XLEN-1:0] RU [NREGS];

   logic            wr_ok;
   logic [AW-1:0]   next_idx;
   logic [XLEN-1:0] next_data;

   assign wr_ok = (state == RUN) && RUWr && !(ZERO_REG && RUrd == '0);

   // Next dump beat sees a same-cycle write to its index (write-through capture).
   always_comb begin
      next_idx  = (dstate == ACTIVE) ? DumpIdx + AW'(1) : '0;
      next_data = (wr_ok && RUrd == next_idx) ? RUDatawr : RU[next_idx];
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      assign a = RUrs[k*AW +: AW];
      always_comb begin
         if (state != RUN || (ZERO_REG && a == '0))
            d = '0;
         else if (BYPASS && wr_ok && a == RUrd)
            d = RUDatawr;
         else
            d = RU[a];
      end
      assign RUout[k*XLEN +: XLEN] = d;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= INIT;
         cnt       <= '0;
         RUReady   <= 1'b0;
         dstate    <= IDLE;
         DumpValid <= 1'b0;
         DumpIdx   <= '0;
         DumpData  <= '0;
         DumpLast  <= 1'b0;
      end else if (state == INIT) begin
         RU[cnt] <= '0;
         cnt     <= cnt + AW'(1);
         if (cnt == AW'(NREGS-1)) begin
            state   <= RUN;
            RUReady <= 1'b1;
         end
      end else begin
         if (wr_ok)
            RU[RUrd] <= RUDatawr;
         if (dstate == IDLE) begin
            if (DumpReq) begin
               dstate    <= ACTIVE;
               DumpValid <= 1'b1;
               DumpIdx   <= next_idx;
               DumpData  <= next_data;
               DumpLast  <= (next_idx == AW'(NREGS-1));
            end
         end else if (DumpReady) begin
            if (DumpIdx == AW'(NREGS-1)) begin
               dstate    <= IDLE;
               DumpValid <= 1'b0;
               DumpLast  <= 1'b0;
            end else begin
               DumpIdx  <= next_idx;
               DumpData <= next_data;
               DumpLast <= (next_idx == AW'(NREGS-1));
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (default build plus a 16x3 no-bypass build)
module tb_regfile_mp;

   logic        CLK = 1'b0;
   logic        RST, RUWr, RUReady, DumpReq, DumpValid, DumpReady, DumpLast;
   logic [9:0]  RUrs;
   logic [63:0] RUout;
   logic [4:0]  RUrd, DumpIdx;
   logic [31:0] RUDatawr, DumpData;

   logic        b_rst, b_wr, b_ready, b_dreq, b_dvalid, b_drdy, b_dlast;
   logic [11:0] b_rs;
   logic [95:0] b_out;
   logic [3:0]  b_rd, b_didx;
   logic [31:0] b_data, b_ddata;

   always #5 CLK = ~CLK;

   regfile_mp dut (
      .CLK(CLK), .RST(RST), .RUrs(RUrs), .RUout(RUout), .RUrd(RUrd),
      .RUDatawr(RUDatawr), .RUWr(RUWr), .RUReady(RUReady), .DumpReq(DumpReq),
      .DumpValid(DumpValid), .DumpReady(DumpReady), .DumpIdx(DumpIdx),
      .DumpData(DumpData), .DumpLast(DumpLast)
   );

   regfile_mp #(.XLEN(32), .NREGS(16), .NRD(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
      .CLK(CLK), .RST(b_rst), .RUrs(b_rs), .RUout(b_out), .RUrd(b_rd),
      .RUDatawr(b_data), .RUWr(b_wr), .RUReady(b_ready), .DumpReq(b_dreq),
      .DumpValid(b_dvalid), .DumpReady(b_drdy), .DumpIdx(b_didx),
      .DumpData(b_ddata), .DumpLast(b_dlast)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: register contents, readiness, dump progress and expected beats.
   typedef struct {int idx; logic [31:0] data;} beat_t;
   logic [31:0] m [32];
   bit          mready;
   int          mcnt;
   bit          mact;
   int          midx;
   beat_t       sb[$];

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (!mready || a == 5'd0) return 32'h0;
      if (RUWr && RUrd == a)    return RUDatawr;
      return m[a];
   endfunction

   always @(negedge CLK) begin
      if (DumpValid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("dump_unexpected_valid", 32'(DumpValid), 32'h0);
         end else begin
            chk("dump_idx", 32'(DumpIdx), 32'(sb[0].idx));
            chk("dump_data", DumpData, sb[0].data);
            chk("dump_last", 32'(DumpLast), 32'(sb[0].idx == 31));
            if (DumpReady) void'(sb.pop_front());
         end
      end
   end

   task automatic step();
      @(negedge CLK); #1;
      chk("ru_ready", 32'(RUReady), 32'(mready));
      for (int k = 0; k < 2; k++)
         chk($sformatf("rd%0d", k), RUout[k*32 +: 32], exp_read(RUrs[k*5 +: 5]));
      if (RST) begin
         mready = 0; mcnt = 0; mact = 0; sb.delete();
      end else if (!mready) begin
         m[mcnt] = 32'h0;
         mcnt++;
         if (mcnt == 32) mready = 1;
      end else begin
         if (RUWr && RUrd != 5'd0) m[RUrd] = RUDatawr;
         if (mact) begin
            if (DumpReady) begin
               if (midx == 31) mact = 0;
               else begin
                  midx++;
                  sb.push_back('{idx: midx, data: m[midx]});
               end
            end
         end else if (DumpReq) begin
            mact = 1; midx = 0;
            sb.push_back('{idx: 0, data: m[0]});
         end
      end
      @(posedge CLK); #1;
   endtask

   task automatic drain();
      DumpReq = 0; DumpReady = 1; RUWr = 0;
      for (int c = 0; c < 40 && mact; c++) begin
         RUrs = 10'($urandom);
         step();
      end
      chk("dump_drained", 32'(mact), 32'h0);
   endtask

   initial begin
      RST = 1; RUWr = 0; RUrd = 0; RUDatawr = 0; RUrs = 0; DumpReq = 0; DumpReady = 0;
      b_rst = 1; b_wr = 0; b_rd = 0; b_data = 0; b_rs = 0; b_dreq = 0; b_drdy = 0;
      step(); step();

      // Clear sweep with a write and dump request that must both be ignored.
      RST = 0; RUWr = 1; RUrd = 5'd3; RUDatawr = 32'hA5A5A5A5; DumpReq = 1;
      for (int i = 0; i < 32; i++) begin
         RUrs = 10'($urandom);
         step();
      end
      RUWr = 0; DumpReq = 0; RUrs = {5'd3, 5'd3};
      step();
      chk("init_write_dropped", RUout[31:0], 32'h0);

      RUWr = 1; RUrd = 5'd5; RUDatawr = 32'hDEADBEEF; RUrs = 10'd0;
      step();
      RUWr = 1; RUrd = 5'd0; RUDatawr = 32'd7; RUrs = {5'd0, 5'd5};
      #1;
      chk("x5_readback", RUout[31:0], 32'hDEADBEEF);
      chk("x0_write_dropped", RUout[63:32], 32'h0);
      step();

      RUWr = 1; RUrd = 5'd9; RUDatawr = 32'h1234; RUrs = {5'd9, 5'd9};
      #1;
      chk("bypass_p0", RUout[31:0], 32'h1234);
      chk("bypass_p1", RUout[63:32], 32'h1234);
      step();

      for (int i = 1; i < 32; i++) begin
         RUWr = 1; RUrd = 5'(i); RUDatawr = 32'(i*3); RUrs = 10'($urandom);
         step();
      end

      // Backpressured dump with writes to the stalled beat and the next-captured beat.
      RUWr = 0; DumpReq = 1; DumpReady = 0;
      step();
      DumpReq = 0;
      for (int c = 0; c < 200 && mact; c++) begin
         DumpReady = c[0];
         RUWr = 0;
         if (midx == 4 && !DumpReady) begin RUWr = 1; RUrd = 5'd4; RUDatawr = 32'h55; end
         if (midx == 5 && DumpReady)  begin RUWr = 1; RUrd = 5'd6; RUDatawr = 32'h66; end
         RUrs = 10'($urandom);
         step();
      end
      chk("dump1_done", 32'(mact), 32'h0);

      for (int i = 0; i < 400; i++) begin
         RUWr = 1'($urandom); RUrd = 5'($urandom); RUDatawr = $urandom;
         RUrs = 10'($urandom); DumpReq = ($urandom_range(0, 7) == 0); DumpReady = 1'($urandom);
         step();
      end
      drain();

      // Abort a dump at beat 7, then a fresh dump right at the end of the sweep.
      DumpReq = 1; DumpReady = 1;
      step();
      DumpReq = 0;
      for (int c = 0; c < 20 && midx < 7; c++) step();
      chk("abort_at_7", 32'(midx), 32'd7);
      RST = 1;
      step();
      chk("abort_valid_low", 32'(DumpValid), 32'h0);
      RST = 0; DumpReq = 1;
      for (int i = 0; i < 33; i++) begin
         RUrs = 10'($urandom);
         step();
      end
      drain();

      // Second build: no zero register, no bypass, 16 registers, 3 read ports.
      @(posedge CLK); #1;
      b_rst = 0;
      for (int e = 0; e < 16; e++) begin
         chk("b_init_ready", 32'(b_ready), 32'h0);
         chk("b_init_out", 32'(b_out == 96'h0), 32'h1);
         @(posedge CLK); #1;
      end
      chk("b_ready", 32'(b_ready), 32'h1);
      b_wr = 1; b_rd = 4'd0; b_data = 32'd7; b_rs = 12'd0;
      #1 chk("b_x0_old", b_out[31:0], 32'h0);
      @(posedge CLK); #1;
      b_wr = 0;
      #1 chk("b_x0_kept", b_out[31:0], 32'd7);
      b_wr = 1; b_rd = 4'd9; b_data = 32'h1234; b_rs = {4'd9, 4'd9, 4'd9};
      #1;
      for (int k = 0; k < 3; k++) chk($sformatf("b_nobypass%0d", k), b_out[k*32 +: 32], 32'h0);
      @(posedge CLK); #1;
      b_wr = 0;
      #1;
      for (int k = 0; k < 3; k++) chk($sformatf("b_after_edge%0d", k), b_out[k*32 +: 32], 32'h1234);
      b_dreq = 1; b_drdy = 1;
      @(posedge CLK); #1;
      b_dreq = 0;
      for (int c = 0; c < 20 && b_didx != 4'd7; c++) begin @(posedge CLK); #1; end
      chk("b_at_7_valid", 32'(b_dvalid), 32'h1);
      chk("b_at_7_idx", 32'(b_didx), 32'd7);
      b_rst = 1;
      @(posedge CLK); #1;
      chk("b_abort_valid", 32'(b_dvalid), 32'h0);
      b_rst = 0; b_dreq = 1;
      for (int e = 0; e < 16; e++) begin
         chk("b_resweep_ready", 32'(b_ready), 32'h0);
         @(posedge CLK); #1;
      end
      chk("b_resweep_done", 32'(b_ready), 32'h1);
      chk("b_x9_cleared", b_out[31:0], 32'h0);
      @(posedge CLK); #1;
      b_dreq = 0;
      chk("b_restart_valid", 32'(b_dvalid), 32'h1);
      chk("b_restart_idx", 32'(b_didx), 32'h0);
      chk("b_restart_data", b_ddata, 32'h0);

      chk("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
